// File: rtl/sine_sched_pkg.sv
// Shared constants for the time-multiplexed sine oscillator scheduler:
// frame states, phase quadrant codes and port-width helpers.
package sine_sched_pkg;

    typedef logic [1:0] sched_state_t;

    localparam sched_state_t ST_IDLE  = 2'd0;
    localparam sched_state_t ST_ISSUE = 2'd1;
    localparam sched_state_t ST_DRAIN = 2'd2;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    // A single voice still needs a one-bit voice tag.
    function automatic int voice_w(input int voices);
        return (voices > 1) ? $clog2(voices) : 1;
    endfunction

    // Sum of one frame: one sample width plus headroom for every voice.
    function automatic int mix_w(input int sin_w, input int voices);
        return sin_w + 1 + voice_w(voices);
    endfunction

endpackage

// File: rtl/sine_quadrant_fold.sv
// Quarter-wave folding: maps phase to a table address on the issue side and
// restores the sign of the returned magnitude, with aligned tag delay line.
module sine_quadrant_fold
    import sine_sched_pkg::*;
#(
    parameter  int VOICES  = 4,
    parameter  int ANGLE_W = 8,
    parameter  int SIN_W   = 16,
    localparam int VW      = voice_w(VOICES)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    issue_go,
    input  logic [ANGLE_W+1:0]      issue_bits,
    input  logic                    issue_enable,
    input  logic [VW-1:0]           issue_voice,
    output logic                    tab_en,
    output logic [ANGLE_W-1:0]      tab_addr,
    input  logic [SIN_W-1:0]        tab_data,
    output logic                    out_valid,
    output logic [VW-1:0]           out_voice,
    output logic signed [SIN_W:0]   out_sin
);

    logic [1:0]         quad_s;
    logic [ANGLE_W-1:0] angle_s;
    logic [ANGLE_W-1:0] addr_s;
    logic [SIN_W:0]     mag_s;
    logic [SIN_W:0]     sin_s;

    logic               tab_en_r;
    logic [ANGLE_W-1:0] tab_addr_r;
    logic [1:0]         s1_quad_r;
    logic               s1_en_r;
    logic [VW-1:0]      s1_voice_r;
    logic               s2_valid_r;
    logic [1:0]         s2_quad_r;
    logic               s2_en_r;
    logic [VW-1:0]      s2_voice_r;
    logic               out_valid_r;
    logic [VW-1:0]      out_voice_r;
    logic [SIN_W:0]     out_sin_r;

    // Odd quadrants walk the quarter wave backwards.
    always_comb begin
        quad_s  = issue_bits[ANGLE_W+1:ANGLE_W];
        angle_s = issue_bits[ANGLE_W-1:0];
        case (quad_s)
            QUAD_0, QUAD_2: addr_s = angle_s;
            QUAD_1, QUAD_3: addr_s = ~angle_s;
            default:        addr_s = angle_s;
        endcase
    end

    // Sign restore; disabled voices contribute silence in their slot.
    always_comb begin
        mag_s = {1'b0, tab_data};
        sin_s = {(SIN_W+1){1'b0}};
        if (s2_en_r) begin
            case (s2_quad_r)
                QUAD_0, QUAD_1: sin_s = mag_s;
                QUAD_2, QUAD_3: sin_s = -mag_s;
                default:        sin_s = mag_s;
            endcase
        end else begin
            sin_s = {(SIN_W+1){1'b0}};
        end
    end

    // Table strobe, then two stages of tags so they meet tab_data, then output.
    always_ff @(posedge clk) begin
        if (reset) begin
            tab_en_r    <= 1'b0;
            tab_addr_r  <= {ANGLE_W{1'b0}};
            s1_quad_r   <= 2'd0;
            s1_en_r     <= 1'b0;
            s1_voice_r  <= {VW{1'b0}};
            s2_valid_r  <= 1'b0;
            s2_quad_r   <= 2'd0;
            s2_en_r     <= 1'b0;
            s2_voice_r  <= {VW{1'b0}};
            out_valid_r <= 1'b0;
            out_voice_r <= {VW{1'b0}};
            out_sin_r   <= {(SIN_W+1){1'b0}};
        end else begin
            tab_en_r <= issue_go;
            if (issue_go) begin
                tab_addr_r <= addr_s;
                s1_quad_r  <= quad_s;
                s1_en_r    <= issue_enable;
                s1_voice_r <= issue_voice;
            end
            s2_valid_r  <= tab_en_r;
            s2_quad_r   <= s1_quad_r;
            s2_en_r     <= s1_en_r;
            s2_voice_r  <= s1_voice_r;
            out_valid_r <= s2_valid_r;
            if (s2_valid_r) begin
                out_voice_r <= s2_voice_r;
                out_sin_r   <= sin_s;
            end
        end
    end

    assign tab_en    = tab_en_r;
    assign tab_addr  = tab_addr_r;
    assign out_valid = out_valid_r;
    assign out_voice = out_voice_r;
    assign out_sin   = out_sin_r;

endmodule

// File: rtl/sine_voice_scheduler.sv
// Shares one quarter-wave sine table among VOICES phase accumulators, one voice
// per cycle per sample_tick. Optional frame mix output under SINE_SCHED_MIX_EN.
module sine_voice_scheduler
    import sine_sched_pkg::*;
#(
    parameter  int VOICES  = 4,
    parameter  int PHASE_W = 24,
    parameter  int ANGLE_W = 8,
    parameter  int SIN_W   = 16,
    localparam int VW      = voice_w(VOICES)
`ifdef SINE_SCHED_MIX_EN
    ,
    localparam int MW      = mix_w(SIN_W, VOICES)
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_tick,
    input  logic                    cfg_we,
    input  logic [VW-1:0]           cfg_voice,
    input  logic [PHASE_W-1:0]      cfg_incr,
    input  logic                    cfg_enable,
    input  logic                    cfg_sync,
    input  logic                    overrun_clr,
    output logic                    tab_en,
    output logic [ANGLE_W-1:0]      tab_addr,
    input  logic [SIN_W-1:0]        tab_data,
    output logic                    out_valid,
    output logic [VW-1:0]           out_voice,
    output logic signed [SIN_W:0]   out_sin,
    output logic                    busy,
    output logic                    overrun
`ifdef SINE_SCHED_MIX_EN
    ,
    output logic                    mix_valid,
    output logic signed [MW-1:0]    mix_out
`endif
);

    localparam logic [VW-1:0] LAST_VOICE = VW'(VOICES - 1);

    sched_state_t       state_r;
    sched_state_t       state_nxt_s;
    logic [VW-1:0]      voice_r;
    logic               drain_r;
    logic               busy_r;
    logic               overrun_r;
    logic               issue_go_s;
    logic [VW-1:0]      issue_idx_s;
    logic [PHASE_W-1:0] phase_r  [VOICES];
    logic [PHASE_W-1:0] incr_r   [VOICES];
    logic               enable_r [VOICES];

    // voice_r names the voice currently on tab_addr; the next one is read now.
    always_comb begin
        state_nxt_s = state_r;
        issue_go_s  = 1'b0;
        issue_idx_s = {VW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (sample_tick) begin
                    issue_go_s  = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (voice_r == LAST_VOICE) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    issue_go_s  = 1'b1;
                    issue_idx_s = voice_r + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Frame sequencing and busy flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
            voice_r <= {VW{1'b0}};
            drain_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            drain_r <= (state_r == ST_DRAIN) ? ~drain_r : 1'b0;
            if (issue_go_s) begin
                voice_r <= issue_idx_s;
            end
        end
    end

    // Sticky overrun; a new overrun beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= 1'b0;
        end else if (sample_tick && (state_r != ST_IDLE)) begin
            overrun_r <= 1'b1;
        end else if (overrun_clr) begin
            overrun_r <= 1'b0;
        end
    end

    // Per-voice state; a config write replaces that voice's phase step this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int v = 0; v < VOICES; v++) begin
                phase_r[v]  <= {PHASE_W{1'b0}};
                incr_r[v]   <= {PHASE_W{1'b0}};
                enable_r[v] <= 1'b0;
            end
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (cfg_we && (cfg_voice == VW'(v))) begin
                    incr_r[v]   <= cfg_incr;
                    enable_r[v] <= cfg_enable;
                    if (cfg_sync) begin
                        phase_r[v] <= {PHASE_W{1'b0}};
                    end
                end else if (issue_go_s && (issue_idx_s == VW'(v)) && enable_r[v]) begin
                    phase_r[v] <= phase_r[v] + incr_r[v];
                end
            end
        end
    end

    sine_quadrant_fold #(
        .VOICES  (VOICES),
        .ANGLE_W (ANGLE_W),
        .SIN_W   (SIN_W)
    ) u_fold (
        .clk          (clk),
        .reset        (reset),
        .issue_go     (issue_go_s),
        .issue_bits   (phase_r[issue_idx_s][PHASE_W-1 -: ANGLE_W+2]),
        .issue_enable (enable_r[issue_idx_s]),
        .issue_voice  (issue_idx_s),
        .tab_en       (tab_en),
        .tab_addr     (tab_addr),
        .tab_data     (tab_data),
        .out_valid    (out_valid),
        .out_voice    (out_voice),
        .out_sin      (out_sin)
    );

    assign busy    = busy_r;
    assign overrun = overrun_r;

`ifdef SINE_SCHED_MIX_EN
    logic signed [MW-1:0] mix_acc_r;
    logic signed [MW-1:0] mix_out_r;
    logic signed [MW-1:0] mix_sum_s;
    logic                 mix_valid_r;

    always_comb begin
        mix_sum_s = mix_acc_r + MW'(out_sin);
    end

    // Frame sum, published the cycle after the last voice's sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            mix_acc_r   <= {MW{1'b0}};
            mix_out_r   <= {MW{1'b0}};
            mix_valid_r <= 1'b0;
        end else begin
            mix_valid_r <= 1'b0;
            if ((state_r == ST_IDLE) && sample_tick) begin
                mix_acc_r <= {MW{1'b0}};
            end else if (out_valid) begin
                mix_acc_r <= mix_sum_s;
            end
            if (out_valid && (out_voice == LAST_VOICE)) begin
                mix_valid_r <= 1'b1;
                mix_out_r   <= mix_sum_s;
            end
        end
    end

    assign mix_valid = mix_valid_r;
    assign mix_out   = mix_out_r;
`endif

endmodule

// File: tb/tb_sine_voice_scheduler.sv
// Directed bench for sine_voice_scheduler with a table stub returning addr*256.
// Mix checks are compiled in when SINE_SCHED_MIX_EN is defined.
module tb_sine_voice_scheduler;

    logic               clk = 1'b0;
    logic               reset;
    logic               sample_tick;
    logic               cfg_we;
    logic [1:0]         cfg_voice;
    logic [23:0]        cfg_incr;
    logic               cfg_enable;
    logic               cfg_sync;
    logic               overrun_clr;
    logic               tab_en;
    logic [7:0]         tab_addr;
    logic [15:0]        tab_data = 16'h0000;
    logic               out_valid;
    logic [1:0]         out_voice;
    logic signed [16:0] out_sin;
    logic               busy;
    logic               overrun;
`ifdef SINE_SCHED_MIX_EN
    logic               mix_valid;
    logic signed [18:0] mix_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int nv       = 0;
    int fr_addr [4];
    int fr_sin  [4];
    int fr_mix  = 0;
    int exp_v1_addr [4] = '{0, 255, 0, 255};
    int exp_v1_sin  [4] = '{0, 65280, 0, -65280};

    always #5 clk = ~clk;

    always @(posedge clk) tab_data <= tab_en ? {tab_addr, 8'h00} : 16'h0000;

    sine_voice_scheduler #(
        .VOICES  (4),
        .PHASE_W (24),
        .ANGLE_W (8),
        .SIN_W   (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_voice   (cfg_voice),
        .cfg_incr    (cfg_incr),
        .cfg_enable  (cfg_enable),
        .cfg_sync    (cfg_sync),
        .overrun_clr (overrun_clr),
        .tab_en      (tab_en),
        .tab_addr    (tab_addr),
        .tab_data    (tab_data),
        .out_valid   (out_valid),
        .out_voice   (out_voice),
        .out_sin     (out_sin),
        .busy        (busy),
        .overrun     (overrun)
`ifdef SINE_SCHED_MIX_EN
        ,
        .mix_valid   (mix_valid),
        .mix_out     (mix_out)
`endif
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (out_valid) nv++;
    endtask

    task automatic cfg(input int v, input int incr, input logic en, input logic sync);
        cfg_we     = 1'b1;
        cfg_voice  = v[1:0];
        cfg_incr   = incr[23:0];
        cfg_enable = en;
        cfg_sync   = sync;
        step();
        cfg_we     = 1'b0;
        cfg_sync   = 1'b0;
    endtask

    // Tick in the current cycle c, then observe c+1..c+8 with timing checks.
    task automatic frame();
        sample_tick = 1'b1;
        step();
        sample_tick = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            check_eq("busy", int'(busy), int'(i <= 6));
            check_eq("tab_en", int'(tab_en), int'(i <= 4));
            check_eq("out_valid", int'(out_valid), int'(i >= 3 && i <= 6));
            if (i <= 4) fr_addr[i-1] = int'(tab_addr);
            if (i >= 3 && i <= 6) begin
                check_eq("out_voice", int'(out_voice), i - 3);
                fr_sin[i-3] = int'(out_sin);
            end
`ifdef SINE_SCHED_MIX_EN
            check_eq("mix_valid", int'(mix_valid), int'(i == 7));
            if (i == 7) fr_mix = int'(mix_out);
`endif
            step();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; sample_tick = 1'b0; cfg_we = 1'b0; cfg_voice = 2'd0;
        cfg_incr = 24'h0; cfg_enable = 1'b0; cfg_sync = 1'b0; overrun_clr = 1'b0;
        step(); step();
        check_eq("rst_tab_en", int'(tab_en), 0);
        check_eq("rst_out_valid", int'(out_valid), 0);
        check_eq("rst_busy", int'(busy), 0);
        reset = 1'b0;
        step();
        check_eq("rst_tab_addr", int'(tab_addr), 0);
        check_eq("rst_out_voice", int'(out_voice), 0);
        check_eq("rst_out_sin", int'(out_sin), 0);
        check_eq("rst_overrun", int'(overrun), 0);

        // All voices disabled after reset: four silent samples.
        frame();
        for (int k = 0; k < 4; k++) begin
            check_eq("rst_frame_addr", fr_addr[k], 0);
            check_eq("rst_frame_sin", fr_sin[k], 0);
        end

        // Voice 0 ramps through the first quadrant, voice 1 steps a quarter turn.
        cfg(0, 32'h004000, 1'b1, 1'b0);
        cfg(1, 32'h400000, 1'b1, 1'b0);
        for (int n = 0; n < 256; n++) begin
            frame();
            check_eq("v0_addr", fr_addr[0], n);
            check_eq("v0_sin", fr_sin[0], n * 256);
            if (n < 4) begin
                check_eq("v1_addr", fr_addr[1], exp_v1_addr[n]);
                check_eq("v1_sin", fr_sin[1], exp_v1_sin[n]);
            end
            if (n == 5) check_eq("v2_disabled_sin", fr_sin[2], 0);
        end

        // Voice 0 now sits at 0x400000: disable holds phase, sync zeroes it.
        cfg(0, 32'h004000, 1'b0, 1'b0);
        frame();
        check_eq("dis_addr", fr_addr[0], 255);
        check_eq("dis_sin", fr_sin[0], 0);
        frame();
        check_eq("dis_hold_addr", fr_addr[0], 255);
        cfg(0, 32'h004000, 1'b1, 1'b1);
        frame();
        check_eq("sync_addr", fr_addr[0], 0);
        check_eq("sync_sin", fr_sin[0], 0);
        frame();
        check_eq("sync_next_addr", fr_addr[0], 1);
        check_eq("sync_next_sin", fr_sin[0], 256);

        // Overrun: second tick at c+2 (with a clear, set wins), clear, tick at c+7.
        nv = 0;
        sample_tick = 1'b1; step();
        sample_tick = 1'b0; step();
        check_eq("ovr_busy_c2", int'(busy), 1);
        sample_tick = 1'b1; overrun_clr = 1'b1; step();
        sample_tick = 1'b0; overrun_clr = 1'b0;
        check_eq("ovr_set_wins", int'(overrun), 1);
        overrun_clr = 1'b1; step();
        overrun_clr = 1'b0;
        check_eq("ovr_clr", int'(overrun), 0);
        step(); step(); step();
        check_eq("ovr_busy_c7", int'(busy), 0);
        check_eq("ovr_samples", nv, 4);
        sample_tick = 1'b1; step();
        sample_tick = 1'b0;
        check_eq("tick_c7_busy", int'(busy), 1);
        check_eq("tick_c7_tab_en", int'(tab_en), 1);
        repeat (8) step();
        check_eq("tick_c7_samples", nv, 8);
        check_eq("tick_c7_no_ovr", int'(overrun), 0);

        // Reset in c+4 of a frame aborts it; phases restart from zero.
        sample_tick = 1'b1; step();
        sample_tick = 1'b0; step(); step(); step();
        reset = 1'b1; step();
        reset = 1'b0;
        check_eq("abort_out_valid", int'(out_valid), 0);
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_tab_en", int'(tab_en), 0);
        nv = 0;
        repeat (6) step();
        check_eq("abort_no_samples", nv, 0);
        cfg(0, 32'h400000, 1'b1, 1'b0);
        frame();
        check_eq("restart_addr0", fr_addr[0], 0);
        check_eq("restart_sin0", fr_sin[0], 0);
        frame();
        check_eq("restart_addr1", fr_addr[0], 255);
        check_eq("restart_sin1", fr_sin[0], 65280);

`ifdef SINE_SCHED_MIX_EN
        reset = 1'b1; step();
        reset = 1'b0; step();
        cfg(0, 32'h400000, 1'b1, 1'b0);
        cfg(1, 32'h400000, 1'b1, 1'b0);
        frame();
        check_eq("mix_frame0", fr_mix, 0);
        frame();
        check_eq("mix_frame1", fr_mix, 130560);
        frame();
        check_eq("mix_frame2", fr_mix, 0);
        frame();
        check_eq("mix_frame3", fr_mix, -130560);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sine_voice_scheduler.md
# sine_voice_scheduler

Time-multiplexes one shared quarter-wave sine table among `VOICES` phase-accumulator oscillators. On each `sample_tick` it walks all voices in order. For each voice it advances the phase, folds the phase into a table address, and restores the sign of the table output. Each voice's signed sample is emitted with a voice tag. It sits between the control/config logic and the `sinetable` ROM, replacing one table per voice.

## Interface
- `VOICES`, 4: number of oscillators, ≥1, ≤16
- `PHASE_W`, 24: phase accumulator width
- `ANGLE_W`, 8: table address width (2^ANGLE_W entries per quarter wave)
- `SIN_W`, 16: unsigned table magnitude width
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high reset
- `sample_tick` in 1: start one frame (all voices)
- `cfg_we` in 1: write voice config
- `cfg_voice` in $clog2(VOICES): voice index for write
- `cfg_incr` in PHASE_W: phase increment
- `cfg_enable` in 1: voice enable
- `cfg_sync` in 1: with `cfg_we`, zero that voice's phase
- `overrun_clr` in 1: clear `overrun`
- `tab_en` out 1: table read strobe
- `tab_addr` out ANGLE_W: table address, registered
- `tab_data` in SIN_W: table output, valid 1 cycle after `tab_en`
- `out_valid` out 1: sample strobe
- `out_voice` out $clog2(VOICES): voice of `out_sin`
- `out_sin` out SIN_W+1: signed sample
- `busy` out 1: frame in progress
- `overrun` out 1: sticky, tick arrived while busy

## Operation
- States:
  - IDLE: `sample_tick` → ISSUE, voice=0.
  - ISSUE: one voice per cycle; after voice VOICES-1 → DRAIN.
  - DRAIN: 2 cycles → IDLE.
- Per voice k in ISSUE:
  - Read `phase[k]`.
  - quadrant = phase[PHASE_W-1:PHASE_W-2].
  - angle = phase[PHASE_W-3:PHASE_W-2-ANGLE_W].
  - `tab_addr` = angle for quadrants 0 and 2, ~angle for quadrants 1 and 3.
  - Write `phase[k] += incr[k]`, modulo 2^PHASE_W.
- Disabled voices:
  - Phase is held.
  - `tab_en` is still issued.
  - `out_sin` = 0, `out_valid` still pulses (fixed slot order).
- Sign restore:
  - quadrants 0 and 1: `out_sin` = +tab_data (zero-extended).
  - quadrants 2 and 3: `out_sin` = −tab_data (two's complement).
  - Quadrant, enable and voice index are delayed to align with `tab_data`.
- Config writes:
  - Take effect immediately, in any state.
  - If the written voice is being issued that cycle, the issue uses the old values.
  - The config write wins over that cycle's phase update.
- `sample_tick` while `busy`:
  - The tick is ignored and `overrun` is set.
  - The frame in progress is unaffected.
  - If `overrun_clr` and a set event occur in the same cycle, set wins.
- Reset values:
  - all phases, incrs and enables 0
  - state IDLE
  - `tab_en`, `tab_addr`, `out_valid`, `out_voice`, `out_sin`, `busy`, `overrun` all 0
- Reset mid-frame: the next cycle is IDLE with all outputs at reset values; no further `out_valid` from the aborted frame.

## Timing
- Tick accepted in cycle c:
  - `tab_en`/`tab_addr` for voice k in cycle c+1+k
  - `tab_data` in c+2+k
  - `out_valid`/`out_sin` registered in c+3+k
- `busy` is high from c+1 through c+VOICES+2.
- The earliest next accepted tick is c+VOICES+3; a tick in any cycle from c+1 through c+VOICES+2 is an overrun.
- `out_valid` pulses on VOICES consecutive cycles per frame.

## Configuration
- `SINE_SCHED_MIX_EN` defined:
  - Adds outputs `mix_valid` (1) and `mix_out` (SIN_W+1+$clog2(VOICES), signed).
  - `mix_out` = sum of all `out_sin` in the frame.
  - `mix_valid` pulses 1 cycle after the last voice's `out_valid`, in cycle c+VOICES+3.
  - Mix accumulator clears at frame start and on reset.
- `SINE_SCHED_MIX_EN` undefined: no mix ports or logic.

## Structure
- Package `sine_sched_pkg`:
  - state enum (IDLE, ISSUE, DRAIN)
  - quadrant constants
  - width helper for `mix_out`
- Sub-module `sine_quadrant_fold`: address fold on the issue side, sign restore on the return side, with the aligned quadrant/enable delay line.
- Phase/incr/enable storage stays in the top module, as register arrays.

## Test plan
Bench settings: VOICES=4, PHASE_W=24, ANGLE_W=8, SIN_W=16; table stub returns addr*256 one cycle after `tab_en`.
- Reset, then tick at c → `out_valid` in c+3..c+6, `out_voice` 0..3, `out_sin`=0; `busy` high c+1..c+6.
- Voice 0: incr=0x004000, enabled; frames n=0..255 → voice 0 `tab_addr`=n, `out_sin`=+n*256.
- Voice 1: incr=0x400000, enabled; frames 0..3 →
  - `tab_addr` = 0, 255, 0, 255
  - `out_sin` = 0, +65280, 0, −65280
- Tick at c, second tick at c+2 → `overrun`=1, 4 samples only; `overrun_clr` → `overrun`=0; tick at c+7 accepted.
- Reset asserted in c+4 of a frame → from c+5 `out_valid`=0, `busy`=0; next frame restarts from phase 0.
- `SINE_SCHED_MIX_EN`: voices 0 and 1 as in the quarter-turn case, frame 1 → `mix_out`=130560 at c+7.
